multi_key_filter: RTL and testbench
===================================

MULTI_KEY_FILTER -- requirements
Module: multi_key_filter

Interface
REQ-001 The block SHALL have parameter N_KEYS, default 4: number of independent key channels, 1..16.
REQ-002 The block SHALL have parameter DEBOUNCE_CYC, default 1_000: stable-level cycles required to accept a press or a release, minimum 2.
REQ-003 The block SHALL have parameter LONG_CYC, default 50_000_000: held cycles after an accepted press before a long-press event, minimum 2.
REQ-004 The block SHALL have parameter CNT_W, default 26: counter width, with 2^CNT_W > max(DEBOUNCE_CYC, LONG_CYC).
REQ-005 The block SHALL have port Clk, input, 1 bit: system clock; all logic is on the rising edge.
REQ-006 The block SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port key, input, N_KEYS bits: raw asynchronous key inputs, active-low (pressed = 0).
REQ-008 The block SHALL have port key_state, output, N_KEYS bits: debounced level per channel (1 = released).
REQ-009 The block SHALL have port key_press, output, N_KEYS bits: one-cycle pulse per channel on each accepted press.
REQ-010 The block SHALL have port key_release, output, N_KEYS bits: one-cycle pulse per channel on each accepted release.
REQ-011 The block SHALL have port key_long, output, N_KEYS bits: one-cycle pulse per channel when a press has been held LONG_CYC cycles.
REQ-012 The block SHALL have port key_flag, output, 1 bit: registered OR of all key_press and key_release bits, delayed 1 cycle.

Function
REQ-013 Each channel SHALL pass key through a 2-flop synchronizer (ks); all FSM decisions SHALL use ks only.
REQ-014 Each channel SHALL have an independent FSM with states IDLE, DB_DOWN, HELD, DB_UP, a debounce counter dcnt, and a hold counter lcnt.
REQ-015 IDLE: ks==0 -> DB_DOWN with dcnt=0; otherwise the channel SHALL stay in IDLE.
REQ-016 DB_DOWN: ks==1 -> IDLE with dcnt=0 and no pulse; dcnt==DEBOUNCE_CYC-1 -> HELD with key_state=0, key_press=1, lcnt=0, long_done=0; otherwise dcnt SHALL increment.
REQ-017 HELD: ks==1 -> DB_UP with dcnt=0; lcnt==LONG_CYC-1 with long_done==0 -> key_long=1 and long_done=1; otherwise lcnt SHALL increment while long_done==0.
REQ-018 key_long SHALL fire at most once per accepted press: no auto-repeat, and lcnt freezes once long_done is set.
REQ-019 DB_UP: ks==0 -> HELD with dcnt=0; lcnt and long_done SHALL be preserved, and lcnt SHALL not advance in DB_UP.
REQ-020 DB_UP: dcnt==DEBOUNCE_CYC-1 -> IDLE with key_state=1, key_release=1; otherwise dcnt SHALL increment.
REQ-021 key_press, key_release and key_long SHALL each be high exactly one cycle per event, and SHALL be 0 in all other cycles.
REQ-022 Latency: with key stable low from before edge 1, key_press SHALL rise at edge DEBOUNCE_CYC+3 and key_long SHALL rise at edge DEBOUNCE_CYC+3+LONG_CYC.
REQ-023 Release latency SHALL be symmetric: key_release SHALL rise DEBOUNCE_CYC+3 edges after key stably returns high.
REQ-024 Channels SHALL be fully independent: simultaneous events on several channels SHALL produce simultaneous pulses on each corresponding bit.
REQ-025 key_press and key_long SHALL be able to coincide only on different channels; on a single channel they are at least LONG_CYC cycles apart.
REQ-026 Counters SHALL never wrap; the parameter limits in REQ-002..REQ-004 guarantee this.

Reset
REQ-027 While Reset_n==0 the block SHALL hold: FSMs in IDLE; dcnt=lcnt=0; long_done=0; synchronizer flops=1; key_state all 1; key_press, key_release, key_long all 0; key_flag=0.
REQ-028 Reset assertion mid-debounce or mid-hold SHALL abort the event with no pulse; after deassertion a key still held low SHALL be re-debounced from IDLE.

Verification (DEBOUNCE_CYC=8, LONG_CYC=20, N_KEYS=4)
REQ-029 Clean press: key[0] driven 0 before edge 1 -> key_press=4'b0001 for one cycle at edge 11, key_state[0]=0 from edge 11, key_flag pulse at edge 12.
REQ-030 Bounce: key[1] low for 5 cycles then high -> no key_press, key_state[1] stays 1.
REQ-031 Long press: key[2] held low for 40 cycles -> key_press[2] at edge 11, single key_long[2] at edge 31, no further key_long, key_release[2] 11 edges after key returns high.
REQ-032 Release glitch: key[0] held, then high for 3 cycles then low -> no key_release, key_state[0] stays 0, and key_long timing is not restarted.
REQ-033 Simultaneous and reset: key[3:0]=0 together -> key_press=4'b1111 on one edge; Reset_n pulsed low while held -> all outputs reset, then re-press pulse 11 edges after release of reset.

Source files
------------

// File: rtl/multi_key_filter.sv
// Per-channel key debouncer: 2-flop sync, IDLE/DB_DOWN/HELD/DB_UP FSM, press/release/long-press pulses.
// Press and release pulses land DEBOUNCE_CYC+3 edges after a stable level change; no backpressure, pulses are fire-and-forget.
module multi_key_filter #(
    parameter int N_KEYS       = 4,
    parameter int DEBOUNCE_CYC = 1_000,
    parameter int LONG_CYC     = 50_000_000,
    parameter int CNT_W        = 26
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic              key_flag
);

    typedef enum logic [1:0] {IDLE, DB_DOWN, HELD, DB_UP} state_t;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [N_KEYS-1:0] sync1_q;
    logic [N_KEYS-1:0] ks_q;
    logic              key_flag_q;

    // Synchronizer idles high so a reset never looks like a press.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q <= '1;
            ks_q    <= '1;
        end else begin
            sync1_q <= key;
            ks_q    <= sync1_q;
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] dcnt_q, dcnt_d;
        logic [CNT_W-1:0] lcnt_q, lcnt_d;
        logic             long_done_q, long_done_d;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             release_q, release_d;
        logic             long_q, long_d;

        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                state_q     <= IDLE;
                dcnt_q      <= '0;
                lcnt_q      <= '0;
                long_done_q <= 1'b0;
                level_q     <= 1'b1;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
                long_q      <= 1'b0;
            end else begin
                state_q     <= state_d;
                dcnt_q      <= dcnt_d;
                lcnt_q      <= lcnt_d;
                long_done_q <= long_done_d;
                level_q     <= level_d;
                press_q     <= press_d;
                release_q   <= release_d;
                long_q      <= long_d;
            end
        end

        always_comb begin
            state_d     = state_q;
            dcnt_d      = dcnt_q;
            lcnt_d      = lcnt_q;
            long_done_d = long_done_q;
            level_d     = level_q;
            press_d     = 1'b0;
            release_d   = 1'b0;
            long_d      = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!ks_q[g]) begin
                        state_d = DB_DOWN;
                        dcnt_d  = '0;
                    end
                end
                DB_DOWN: begin
                    if (ks_q[g]) begin
                        state_d = IDLE;
                        dcnt_d  = '0;
                    end else if (dcnt_q == DB_LAST) begin
                        state_d     = HELD;
                        level_d     = 1'b0;
                        press_d     = 1'b1;
                        lcnt_d      = '0;
                        long_done_d = 1'b0;
                    end else begin
                        dcnt_d = dcnt_q + CNT_ONE;
                    end
                end
                HELD: begin
                    // A release bounce wins over the long-press check; lcnt is kept for the return.
                    if (ks_q[g]) begin
                        state_d = DB_UP;
                        dcnt_d  = '0;
                    end else if (!long_done_q) begin
                        if (lcnt_q == LONG_LAST) begin
                            long_d      = 1'b1;
                            long_done_d = 1'b1;
                        end else begin
                            lcnt_d = lcnt_q + CNT_ONE;
                        end
                    end
                end
                DB_UP: begin
                    if (!ks_q[g]) begin
                        state_d = HELD;
                        dcnt_d  = '0;
                    end else if (dcnt_q == DB_LAST) begin
                        state_d   = IDLE;
                        level_d   = 1'b1;
                        release_d = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q + CNT_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        assign key_state[g]   = level_q;
        assign key_press[g]   = press_q;
        assign key_release[g] = release_q;
        assign key_long[g]    = long_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) key_flag_q <= 1'b0;
        else          key_flag_q <= |(key_press | key_release);
    end

    assign key_flag = key_flag_q;

endmodule

// File: tb/tb_multi_key_filter.sv
// Scoreboard bench for multi_key_filter: run-length reference model pushes expected outputs per edge, monitor pops and compares.
module tb_multi_key_filter;
    localparam int N = 4;
    localparam int D = 8;
    localparam int L = 20;

    logic         Clk = 1'b0;
    logic         Reset_n = 1'b0;
    logic [N-1:0] key = '1;
    logic [N-1:0] key_state, key_press, key_release, key_long;
    logic         key_flag;

    always #5 Clk = ~Clk;

    multi_key_filter #(.N_KEYS(N), .DEBOUNCE_CYC(D), .LONG_CYC(L), .CNT_W(8)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .key(key),
        .key_state(key_state), .key_press(key_press), .key_release(key_release),
        .key_long(key_long), .key_flag(key_flag)
    );

    typedef struct packed {
        logic [N-1:0] st;
        logic [N-1:0] pr;
        logic [N-1:0] rl;
        logic [N-1:0] lg;
        logic         fl;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   press_cyc[N], rel_cyc[N], long_cyc[N];
    int   press_cnt[N], rel_cnt[N], long_cnt[N];

    // Reference model: a level flips after D+1 consecutive synchronized samples at the
    // opposite level; a long press fires on the L-th edge with two consecutive low samples.
    logic [N-1:0] m_s1 = '1, m_s2 = '1, m_pv = '1, m_lvl = '1, m_ld = '0;
    int           m_run[N];
    int           m_hold[N];
    logic         m_evt = 1'b0;

    always @(posedge Clk) begin
        exp_t         e;
        logic [N-1:0] v;
        cyc++;
        e = '0;
        if (!Reset_n) begin
            m_s1 = '1; m_s2 = '1; m_pv = '1; m_lvl = '1; m_ld = '0; m_evt = 1'b0;
            for (int i = 0; i < N; i++) begin m_run[i] = 0; m_hold[i] = 0; end
            e.st = '1;
        end else begin
            v    = m_s2;
            m_s2 = m_s1;
            m_s1 = key;
            for (int i = 0; i < N; i++) begin
                if (!m_lvl[i] && !m_ld[i] && !v[i] && !m_pv[i]) begin
                    m_hold[i]++;
                    if (m_hold[i] == L) begin e.lg[i] = 1'b1; m_ld[i] = 1'b1; end
                end
                if (v[i] != m_lvl[i]) m_run[i]++;
                else                  m_run[i] = 0;
                if (m_run[i] == D + 1) begin
                    m_run[i] = 0;
                    m_lvl[i] = ~m_lvl[i];
                    if (!m_lvl[i]) begin e.pr[i] = 1'b1; m_hold[i] = 0; m_ld[i] = 1'b0; end
                    else           e.rl[i] = 1'b1;
                end
                m_pv[i] = v[i];
            end
            e.fl  = m_evt;
            m_evt = |(e.pr | e.rl);
            e.st  = m_lvl;
        end
        exp_q.push_back(e);
    end

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%b required=%b", nm, cyc, act, req);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #2;
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL scoreboard_empty cyc=%0d actual=0 entries required=1", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("key_state",   key_state,   e.st);
                chk("key_press",   key_press,   e.pr);
                chk("key_release", key_release, e.rl);
                chk("key_long",    key_long,    e.lg);
                chk("key_flag",    {{(N-1){1'b0}}, key_flag}, {{(N-1){1'b0}}, e.fl});
            end
            for (int i = 0; i < N; i++) begin
                if (key_press[i])   begin press_cyc[i] = cyc; press_cnt[i]++; end
                if (key_release[i]) begin rel_cyc[i]   = cyc; rel_cnt[i]++;   end
                if (key_long[i])    begin long_cyc[i]  = cyc; long_cnt[i]++;  end
            end
        end
    end

    task automatic clear_events();
        for (int i = 0; i < N; i++) begin
            press_cyc[i] = -1; rel_cyc[i] = -1; long_cyc[i] = -1;
            press_cnt[i] = 0;  rel_cnt[i] = 0;  long_cnt[i] = 0;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    initial begin
        int t;
        int dur[N];
        clear_events();
        wait_cyc(3);
        Reset_n = 1'b1;
        wait_cyc(5);

        // Clean press and release on key[0]
        clear_events();
        t = cyc; key[0] = 1'b0;
        wait_cyc(30);
        chk_int("press0_edge", press_cyc[0], t + 11);
        chk_int("press0_count", press_cnt[0], 1);
        t = cyc; key[0] = 1'b1;
        wait_cyc(20);
        chk_int("release0_edge", rel_cyc[0], t + 11);

        // Bounce on key[1] shorter than the debounce window
        clear_events();
        key[1] = 1'b0; wait_cyc(5);
        key[1] = 1'b1; wait_cyc(20);
        chk_int("bounce1_no_press", press_cnt[1], 0);

        // Long press on key[2]
        clear_events();
        t = cyc; key[2] = 1'b0;
        wait_cyc(40);
        chk_int("long2_edge", long_cyc[2], t + 31);
        chk_int("long2_count", long_cnt[2], 1);
        t = cyc; key[2] = 1'b1;
        wait_cyc(20);
        chk_int("release2_edge", rel_cyc[2], t + 11);

        // Release glitch on key[0]: long press is delayed by the glitch, not restarted
        clear_events();
        t = cyc; key[0] = 1'b0;
        wait_cyc(14);
        key[0] = 1'b1; wait_cyc(3);
        key[0] = 1'b0; wait_cyc(30);
        chk_int("glitch0_no_release", rel_cnt[0], 0);
        chk_int("glitch0_long_edge", long_cyc[0], t + 35);
        chk_int("glitch0_long_count", long_cnt[0], 1);
        key[0] = 1'b1; wait_cyc(20);

        // Simultaneous press, then reset while held
        clear_events();
        t = cyc; key = '0;
        wait_cyc(15);
        for (int i = 0; i < N; i++) chk_int("simul_press_edge", press_cyc[i], t + 11);
        Reset_n = 1'b0; wait_cyc(3);
        clear_events();
        t = cyc; Reset_n = 1'b1;
        wait_cyc(15);
        for (int i = 0; i < N; i++) chk_int("repress_edge", press_cyc[i], t + 11);
        key = '1; wait_cyc(20);

        // Random per-channel level runs with occasional resets
        for (int i = 0; i < N; i++) dur[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (dur[i] == 0) begin
                    key[i] = ~key[i];
                    dur[i] = $urandom_range(1, 35);
                end
                dur[i]--;
            end
            if ($urandom_range(0, 599) == 0) Reset_n = 1'b0;
            else if (!Reset_n && $urandom_range(0, 2) == 0) Reset_n = 1'b1;
            wait_cyc(1);
        end
        Reset_n = 1'b1;
        key = '1;
        wait_cyc(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
